// File: rtl/cla4_lcu_if.sv
// Bundles the 4-bit lookahead adder and the 4-group lookahead carry unit signal sets.
// The master drives operands and group terms; the slave (the block) returns results.
interface cla4_lcu_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       cIn;
  logic [3:0] s;
  logic       cOut;
  logic       pg;
  logic       gg;
  logic [3:0] p;
  logic [3:0] g;
  logic       lcIn;
  logic [3:1] c;
  logic       lcOut;
  logic       lpg;
  logic       lgg;

  modport master (
    output a, b, cIn, p, g, lcIn,
    input  s, cOut, pg, gg, c, lcOut, lpg, lgg
  );

  modport slave (
    input  a, b, cIn, p, g, lcIn,
    output s, cOut, pg, gg, c, lcOut, lpg, lgg
  );
endinterface

// File: rtl/cla4_lcu.sv
// 4-bit two-level carry-lookahead adder plus an independent 4-group lookahead carry unit,
// with optional single-stage output registering (REG_OUT).
module cla4_lcu #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  cla4_lcu_if.slave  bus
);

  // Adder per-bit propagate/generate.
  logic [3:0] ap;
  logic [3:0] ag;
  logic [4:0] k;
  logic [3:0] sum;
  logic       add_pg;
  logic       add_gg;

  assign ap = bus.a ^ bus.b;
  assign ag = bus.a & bus.b;

  // Every carry is a flat sum-of-products of cIn; no carry depends on another carry.
  assign k[0] = bus.cIn;
  assign k[1] = ag[0] | (ap[0] & bus.cIn);
  assign k[2] = ag[1] | (ap[1] & ag[0]) | (ap[1] & ap[0] & bus.cIn);
  assign k[3] = ag[2] | (ap[2] & ag[1]) | (ap[2] & ap[1] & ag[0])
              | (ap[2] & ap[1] & ap[0] & bus.cIn);

  assign sum    = ap ^ k[3:0];
  assign add_pg = &ap;
  assign add_gg = ag[3] | (ap[3] & ag[2]) | (ap[3] & ap[2] & ag[1])
                | (ap[3] & ap[2] & ap[1] & ag[0]);
  assign k[4]   = add_gg | (add_pg & bus.cIn);

  // Lookahead carry unit on externally supplied group terms.
  logic [3:1] lc;
  logic       l_pg;
  logic       l_gg;
  logic       l_cout;

  assign lc[1] = bus.g[0] | (bus.p[0] & bus.lcIn);
  assign lc[2] = bus.g[1] | (bus.p[1] & bus.g[0]) | (bus.p[1] & bus.p[0] & bus.lcIn);
  assign lc[3] = bus.g[2] | (bus.p[2] & bus.g[1]) | (bus.p[2] & bus.p[1] & bus.g[0])
               | (bus.p[2] & bus.p[1] & bus.p[0] & bus.lcIn);
  assign l_pg   = &bus.p;
  assign l_gg   = bus.g[3] | (bus.p[3] & bus.g[2]) | (bus.p[3] & bus.p[2] & bus.g[1])
                | (bus.p[3] & bus.p[2] & bus.p[1] & bus.g[0]);
  assign l_cout = l_gg | (l_pg & bus.lcIn);

  // Packed result: {s, cOut, pg, gg, c[3:1], lcOut, lpg, lgg}.
  logic [12:0] res_d;
  logic [12:0] res_q;

  assign res_d = {sum, k[4], add_pg, add_gg, lc, l_cout, l_pg, l_gg};

  generate
    if (REG_OUT) begin : g_reg
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      always_ff @(posedge clk) begin
        if (reset) res_q <= '0;
        else       res_q <= res_d;
      end
    end else begin : g_comb
      logic unused_clk_reset;
      assign unused_clk_reset = clk ^ reset;
      assign res_q = res_d;
    end
  endgenerate

  assign {bus.s, bus.cOut, bus.pg, bus.gg, bus.c, bus.lcOut, bus.lpg, bus.lgg} = res_q;

endmodule

// File: tb/tb_cla4_lcu.sv
// Self-checking bench: registered and combinational instances against an arithmetic reference model.
module tb_cla4_lcu;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  cla4_lcu_if reg_if ();
  cla4_lcu_if comb_if ();

  cla4_lcu #(.REG_OUT(1'b1)) dut_reg  (.clk(clk), .reset(reset), .bus(reg_if));
  cla4_lcu #(.REG_OUT(1'b0)) dut_comb (.clk(clk), .reset(reset), .bus(comb_if));

  // Both instances see identical stimulus.
  assign comb_if.a    = reg_if.a;
  assign comb_if.b    = reg_if.b;
  assign comb_if.cIn  = reg_if.cIn;
  assign comb_if.p    = reg_if.p;
  assign comb_if.g    = reg_if.g;
  assign comb_if.lcIn = reg_if.lcIn;

  logic [12:0] reg_vec;
  logic [12:0] comb_vec;
  assign reg_vec  = {reg_if.s, reg_if.cOut, reg_if.pg, reg_if.gg,
                     reg_if.c, reg_if.lcOut, reg_if.lpg, reg_if.lgg};
  assign comb_vec = {comb_if.s, comb_if.cOut, comb_if.pg, comb_if.gg,
                     comb_if.c, comb_if.lcOut, comb_if.lpg, comb_if.lgg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // True when p[lo..hi] are all ones (an empty span counts as true).
  function automatic bit span_ones(input logic [3:0] p, input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      if (!p[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Adder from integer addition; LCU carry into position k exists if some generate
  // below k survives an all-propagate span up to k, or lcIn survives the whole span.
  function automatic logic [12:0] model(input logic [3:0] a, input logic [3:0] b,
                                        input logic ci, input logic [3:0] p,
                                        input logic [3:0] g, input logic li);
    int         total;
    logic [3:0] s;
    logic       co;
    logic       apg;
    logic       agg;
    logic [4:1] carry;
    logic       lgg;
    total = int'(a) + int'(b) + int'(ci);
    s     = total[3:0];
    co    = (total >= 16);
    apg   = ((a ^ b) == 4'hF);
    agg   = ((int'(a) + int'(b)) >= 16);
    for (int kk = 1; kk <= 4; kk++) begin
      carry[kk] = li && span_ones(p, 0, kk - 1);
      for (int j = 0; j < kk; j++)
        if (g[j] && span_ones(p, j + 1, kk - 1)) carry[kk] = 1'b1;
    end
    lgg = 1'b0;
    for (int j = 0; j < 4; j++)
      if (g[j] && span_ones(p, j + 1, 3)) lgg = 1'b1;
    return {s, co, apg, agg, carry[3:1], carry[4], &p, lgg};
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci,
                       input logic [3:0] p, input logic [3:0] g, input logic li);
    reg_if.a    = a;
    reg_if.b    = b;
    reg_if.cIn  = ci;
    reg_if.p    = p;
    reg_if.g    = g;
    reg_if.lcIn = li;
  endtask

  // Drive one vector, check the combinational instance at once and the registered one an edge later.
  task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic ci, input logic [3:0] p, input logic [3:0] g,
                       input logic li);
    logic [12:0] exp;
    drive(a, b, ci, p, g, li);
    exp = model(a, b, ci, p, g, li);
    #1;
    check({tag, "_comb"}, comb_vec, exp);
    @(posedge clk);
    #1;
    check({tag, "_reg"}, reg_vec, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset with busy inputs: registered outputs must be zero.
    reset = 1'b1;
    drive(4'hF, 4'h1, 1'b1, 4'hF, 4'hF, 1'b1);
    @(posedge clk);
    #1;
    check("reset_state", reg_vec, 13'h0);
    @(posedge clk);
    #1;
    check("reset_hold", reg_vec, 13'h0);

    // First cycle after deassertion captures normally.
    reset = 1'b0;
    apply("add_1_1",        4'h1, 4'h1, 1'b0, 4'hF, 4'h0, 1'b1);
    check("add_1_1_const",  reg_vec, {4'h2, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 1'b1, 1'b0});
    apply("add_7_1",        4'h7, 4'h1, 1'b0, 4'hF, 4'h0, 1'b0);
    check("lcu_prop_zero",  reg_vec, {4'h8, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0});
    apply("add_F_1",        4'hF, 4'h1, 1'b0, 4'h0, 4'h1, 1'b0);
    check("add_F_1_const",  reg_vec, {4'h0, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0});
    apply("add_C_4",        4'hC, 4'h4, 1'b0, 4'hE, 4'h1, 1'b0);
    check("lcu_g0_chain",   reg_vec, {4'h0, 1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 1'b1});
    apply("add_A_5_c1",     4'hA, 4'h5, 1'b1, 4'h0, 4'h0, 1'b1);
    check("add_A_5_const",  reg_vec, {4'h0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0});

    // Mid-stream reset discards the in-flight vector.
    apply("pre_reset",      4'h9, 4'h6, 1'b1, 4'h5, 4'hA, 1'b1);
    drive(4'h3, 4'hD, 1'b1, 4'hF, 4'hF, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midstream_reset", reg_vec, 13'h0);
    reset = 1'b0;
    apply("post_reset",     4'h3, 4'hD, 1'b1, 4'hF, 4'hF, 1'b1);

    // Exhaustive adder sweep at full throughput, random LCU terms alongside.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      apply($sformatf("sweep_%0d", i), v[3:0], v[7:4], v[8],
            4'($urandom), 4'($urandom), 1'($urandom));
    end

    // Random vectors across both paths.
    for (int i = 0; i < 150; i++)
      apply($sformatf("rand_%0d", i), 4'($urandom), 4'($urandom), 1'($urandom),
            4'($urandom), 4'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
